// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - state encoding and bit-order constants shared by the shift-register family
package shift_reg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2
   } state_t;

   localparam bit ORDER_MSB_FIRST = 1'b1;
   localparam bit ORDER_LSB_FIRST = 1'b0;

endpackage

// File: rtl/deser_out_buffer.sv
// rtl/deser_out_buffer.sv - one-word holding register with valid/ready handshake and overrun pulse
module deser_out_buffer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] word,
   input  logic             word_parity_err,
   input  logic             data_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             parity_err,
   output logic             overrun
);

   logic transfer;
   logic accept;

   assign transfer = data_valid & data_ready;
   // A completing word may replace the held one only if the slot is empty or draining now.
   assign accept   = load & (~data_valid | transfer);

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= load & ~accept;
         if (accept) begin
            data_out   <= word;
            data_valid <= 1'b1;
            parity_err <= word_parity_err;
         end else if (transfer) begin
            data_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/serial_deserializer.sv
// rtl/serial_deserializer.sv - framed serial-to-parallel receiver with one-word output buffer
// Optional trailing parity bit per frame is enabled by defining DESER_PARITY_EN.
module serial_deserializer
   import shift_reg_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             serial_in,
   input  logic             shift_en,
   input  logic             sync,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   input  logic             data_ready,
   output logic             busy,
   output logic             overrun,
   output logic             parity_err
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state, next_state;
   logic [CW-1:0]    cnt, next_cnt;
   logic [WIDTH-1:0] sr, next_sr;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] first_bit;
   logic [WIDTH-1:0] word;
   logic             word_parity_err;
   logic             complete;

   assign shifted   = (MSB_FIRST == ORDER_LSB_FIRST) ? {serial_in, sr[WIDTH-1:1]}
                                                     : {sr[WIDTH-2:0], serial_in};
   assign first_bit = (MSB_FIRST == ORDER_MSB_FIRST) ? {{(WIDTH-1){1'b0}}, serial_in}
                                                     : {serial_in, {(WIDTH-1){1'b0}}};

   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      next_sr    = sr;
      complete   = 1'b0;
      // sync restarts framing from any state, overriding completion and the parity wait.
      if (sync) begin
         next_state = ST_SHIFT;
         next_cnt   = shift_en ? CW'(1) : '0;
         next_sr    = shift_en ? first_bit : '0;
      end else begin
         case (state)
            ST_SHIFT: begin
               if (shift_en) begin
                  next_sr  = shifted;
                  next_cnt = cnt + CW'(1);
                  if (cnt == CW'(WIDTH - 1)) begin
`ifdef DESER_PARITY_EN
                     next_state = ST_PARITY;
`else
                     complete   = 1'b1;
                     next_state = ST_IDLE;
                     next_cnt   = '0;
`endif
                  end
               end
            end
`ifdef DESER_PARITY_EN
            ST_PARITY: begin
               if (shift_en) begin
                  complete   = 1'b1;
                  next_state = ST_IDLE;
                  next_cnt   = '0;
               end
            end
`endif
            default: ;
         endcase
      end
   end

`ifdef DESER_PARITY_EN
   // In the parity state sr already holds the full word; serial_in is the parity bit.
   assign word            = sr;
   assign word_parity_err = ((^sr) ^ serial_in) != PARITY_ODD;
`else
   logic unused_parity_sense;
   assign unused_parity_sense = PARITY_ODD;
   assign word            = shifted;
   assign word_parity_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state <= ST_IDLE;
         cnt   <= '0;
         sr    <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
         sr    <= next_sr;
      end
   end

   assign busy = (state != ST_IDLE);

   deser_out_buffer #(
      .WIDTH(WIDTH)
   ) u_out_buffer (
      .clk            (clk),
      .clear          (clear),
      .load           (complete),
      .word           (word),
      .word_parity_err(word_parity_err),
      .data_ready     (data_ready),
      .data_out       (data_out),
      .data_valid     (data_valid),
      .parity_err     (parity_err),
      .overrun        (overrun)
   );

endmodule
